shift_pipe: RTL and testbench
=============================

Name: shift_pipe

Overview:
Parametrised, pipelined barrel shifter for the ALU datapath. Supports logical left, logical right and arithmetic right shifts, plus optional rotate-right, over a WIDTH-bit operand. One mux level is registered per shift-amount bit. A valid/ready handshake on both sides supports backpressure. A sideband tag (e.g. destination register id) travels alongside the data.

Parameters:
WIDTH, 32, operand width in bits; power of two, at least 2
TAG_W, 5, width of sideband tag carried with each operation
SHAMT_W, log2(WIDTH), shift-amount width; derived, not overridden

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous; invalidates every in-flight operation
in_valid  in  1  input operation present
in_ready  out  1  shifter accepts input this cycle
in_data  in  WIDTH  operand; bit 0 is MSB
in_shamt  in  SHAMT_W  shift amount; bit 0 is MSB (largest power of two)
in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
in_tag  in  TAG_W  sideband tag, passed through unchanged
out_valid  out  1  result present
out_ready  in  1  consumer accepts result this cycle
out_data  out  WIDTH  shifted result; bit 0 is MSB
out_tag  out  TAG_W  tag of the result

Behaviour:
- Pipeline has SHAMT_W stages, indexed k = 0..SHAMT_W-1. Each stage holds: valid, data, remaining shamt bits, op, tag.
- Stage k conditionally shifts by 2^(SHAMT_W-1-k), controlled by shamt bit k. Stage 0 shifts by WIDTH/2; the last stage shifts by 1.
- Shift semantics per stage when the selected bit is 1:
  - SLL: zero-fill at LSB end.
  - SRL: zero-fill at MSB end.
  - SRA: fill with the stage's current bit 0. Sign is preserved through earlier stages, so this equals the original MSB.
  - ROR: bits shifted out at the LSB end re-enter at the MSB end.
- Selected bit 0: data passes unchanged.
- Latency: SHAMT_W cycles from input acceptance to out_valid, with no stall (5 for WIDTH=32). Throughput: one operation per cycle.
- Handshake:
  - Input transfer occurs when in_valid and in_ready are both high.
  - Output transfer occurs when out_valid and out_ready are both high.
  - Stage k advances when stage k+1 is empty or advancing. The last stage advances when empty or out_ready is high.
  - in_ready = stage 0 advances. in_ready is combinational from out_ready through the valid chain.
  - in_data, in_shamt, in_op and in_tag are sampled only on transfer. out_data and out_tag hold stable while out_valid is high and out_ready is low.
- Ordering: results leave in acceptance order; no reordering or dropping under backpressure.
- Shift amount 0: result equals operand for every op.
- Maximum amount WIDTH-1:
  - SLL leaves only the original LSB, in bit 0.
  - SRL leaves only the original MSB, in bit WIDTH-1.
  - SRA yields all copies of the MSB.
- Flush: on a clock edge with flush high, all stage valids clear. An input presented in the same cycle is not accepted (in_ready is forced low while flush is high).
- Reset: all stage valid bits clear asynchronously. out_valid=0, out_data=0, out_tag=0, and in_ready=1 once reset deasserts. Reset mid-operation discards all in-flight work.
- Data registers on empty stages are don't-care internally, but out_data must read 0 while out_valid=0 after reset, until the first result.

Optional Feature:
SHIFT_ROTATE_EN.
- Defined: op 11 performs rotate-right as above.
- Undefined: op 11 behaves exactly as SRL (01), and the rotate wrap logic is not instantiated.

Decomposition:
- Package shift_pkg holds:
  - op encoding constants SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR;
  - the 2-bit op typedef;
  - a ceiling-log2 function for SHAMT_W.
- Sub-module shift_pipe_stage: one registered mux level.
  - Parameters: WIDTH, TAG_W, AMOUNT (shift distance).
  - Contains the valid register, data/op/tag registers, the conditional shift, and the local advance logic.
  - shift_pipe instantiates SHAMT_W of these in a generate loop and connects the ready chain.

Test Plan:
- SLL 0x00000001 by 31, tag 7, out_ready=1 → after 5 cycles: out_data=0x80000000, out_tag=7.
- SRA 0x80000000 by 4 → 0xF8000000. SRL of the same operand by 4 → 0x08000000. Issue back-to-back; results arrive on consecutive cycles.
- ROR 0x000000FF by 8 → 0xFF000000 with SHIFT_ROTATE_EN. Without it → 0x00000000.
- Backpressure: out_ready=0, send 7 ops with shamt 0..6 →
  - in_ready drops after 5 acceptances;
  - raising out_ready drains all 7 in order with correct values;
  - out_data stays stable while stalled.
- Flush with 3 ops in flight → no out_valid afterwards. A new op issued the next cycle returns correctly after 5 cycles.
- Assert reset mid-stream → out_valid=0 and out_data=0 immediately (asynchronously). After deassertion in_ready=1, and the first new result is correct.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and the
// ceiling-log2 helper used to size the shift amount.
package shift_pkg;

  typedef logic [1:0] shift_op_t;

  localparam shift_op_t SHIFT_SLL = 2'b00;
  localparam shift_op_t SHIFT_SRL = 2'b01;
  localparam shift_op_t SHIFT_SRA = 2'b10;
  localparam shift_op_t SHIFT_ROR = 2'b11;

  function automatic int shift_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// Operation/result handshake bundle for shift_pipe. Data and shift amount are
// declared ascending so index 0 is the most significant bit.
interface shift_pipe_if
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);

  localparam int SHAMT_W = shift_clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [0:WIDTH-1]   in_data;
  logic [0:SHAMT_W-1] in_shamt;
  shift_op_t          in_op;
  logic [TAG_W-1:0]   in_tag;

  logic               out_valid;
  logic               out_ready;
  logic [0:WIDTH-1]   out_data;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/shift_pipe_stage.sv
// One registered mux level of the barrel shifter: conditionally shifts by AMOUNT.
// Rotate wrap logic exists only when SHIFT_ROTATE_EN is defined; otherwise ROR acts as SRL.
module shift_pipe_stage
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int TAG_W  = 5,
  parameter int AMOUNT = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            up_valid_i,
  input  logic [0:WIDTH-1]                up_data_i,
  input  logic [0:shift_clog2(WIDTH)-1]   up_shamt_i,
  input  shift_op_t                       up_op_i,
  input  logic [TAG_W-1:0]                up_tag_i,
  input  logic                            ds_adv_i,
  output logic                            valid_o,
  output logic [0:WIDTH-1]                data_o,
  output logic [0:shift_clog2(WIDTH)-1]   shamt_o,
  output shift_op_t                       op_o,
  output logic [TAG_W-1:0]                tag_o
);

  localparam int SHAMT_W = shift_clog2(WIDTH);
  // Stage with AMOUNT = 2^j is steered by shamt bit SHAMT_W-1-j (bit 0 is the MSB).
  localparam int SEL_IDX = SHAMT_W - 1 - shift_clog2(AMOUNT);

  function automatic logic [0:WIDTH-1] shift_data(input logic [0:WIDTH-1] d,
                                                  input shift_op_t         op);
    logic signed [0:WIDTH-1] sd;
    logic        [0:WIDTH-1] r;
    sd = d;
    case (op)
      SHIFT_SLL: r = d << AMOUNT;
      SHIFT_SRA: r = sd >>> AMOUNT;
`ifdef SHIFT_ROTATE_EN
      SHIFT_ROR: r = (d >> AMOUNT) | (d << (WIDTH - AMOUNT));
`endif
      default:   r = d >> AMOUNT;
    endcase
    return r;
  endfunction

  logic                 vld_q;
  logic [0:WIDTH-1]     data_q;
  logic [0:WIDTH-1]     data_d;
  logic [0:SHAMT_W-1]   shamt_q;
  shift_op_t            op_q;
  logic [TAG_W-1:0]     tag_q;
  logic                 adv;

  assign adv    = !vld_q || ds_adv_i;
  assign data_d = up_shamt_i[SEL_IDX] ? shift_data(up_data_i, up_op_i) : up_data_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= 1'b0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (adv) begin
      vld_q <= up_valid_i;
    end
  end

  // Payload is only meaningful while vld_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (adv && up_valid_i) begin
      data_q  <= data_d;
      shamt_q <= up_shamt_i;
      op_q    <= up_op_i;
      tag_q   <= up_tag_i;
    end
  end

  assign valid_o = vld_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign op_o    = op_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA, ROR when SHIFT_ROTATE_EN is defined),
// one registered level per shift-amount bit, with valid/ready backpressure.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  shift_pipe_if.slave  bus
);

  localparam int SHAMT_W = shift_clog2(WIDTH);
  localparam int LAST    = SHAMT_W - 1;

  logic                acc_vld;
  logic                vld_s   [SHAMT_W];
  logic [0:WIDTH-1]    data_s  [SHAMT_W];
  logic [0:SHAMT_W-1]  shamt_s [SHAMT_W];
  shift_op_t           op_s    [SHAMT_W];
  logic [TAG_W-1:0]    tag_s   [SHAMT_W];
  logic                adv     [SHAMT_W+1];

  // adv[k]: stage k may load this cycle; adv[SHAMT_W] is the consumer's ready.
  always_comb begin
    adv[SHAMT_W] = bus.out_ready;
    for (int k = SHAMT_W - 1; k >= 0; k--) begin
      adv[k] = !vld_s[k] || adv[k+1];
    end
  end

  assign bus.in_ready = adv[0] && !flush;
  assign acc_vld      = bus.in_valid && bus.in_ready;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    logic               up_vld;
    logic [0:WIDTH-1]   up_data;
    logic [0:SHAMT_W-1] up_shamt;
    shift_op_t          up_op;
    logic [TAG_W-1:0]   up_tag;

    if (k == 0) begin : g_src
      assign up_vld   = acc_vld;
      assign up_data  = bus.in_data;
      assign up_shamt = bus.in_shamt;
      assign up_op    = bus.in_op;
      assign up_tag   = bus.in_tag;
    end else begin : g_src
      assign up_vld   = vld_s[k-1];
      assign up_data  = data_s[k-1];
      assign up_shamt = shamt_s[k-1];
      assign up_op    = op_s[k-1];
      assign up_tag   = tag_s[k-1];
    end

    shift_pipe_stage #(
      .WIDTH  (WIDTH),
      .TAG_W  (TAG_W),
      .AMOUNT (1 << (SHAMT_W - 1 - k))
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .up_valid_i (up_vld),
      .up_data_i  (up_data),
      .up_shamt_i (up_shamt),
      .up_op_i    (up_op),
      .up_tag_i   (up_tag),
      .ds_adv_i   (adv[k+1]),
      .valid_o    (vld_s[k]),
      .data_o     (data_s[k]),
      .shamt_o    (shamt_s[k]),
      .op_o       (op_s[k]),
      .tag_o      (tag_s[k])
    );
  end

  // Masking keeps the output at zero whenever no result is presented.
  assign bus.out_valid = vld_s[LAST];
  assign bus.out_data  = vld_s[LAST] ? data_s[LAST] : '0;
  assign bus.out_tag   = vld_s[LAST] ? tag_s[LAST]  : '0;

endmodule

// File: tb/tb_shift_pipe.sv
// Directed self-checking bench for shift_pipe (WIDTH=32, TAG_W=5); ROR expectations
// follow SHIFT_ROTATE_EN.
module tb_shift_pipe;
  import shift_pkg::*;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  shift_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  v_op   [8];
  logic [31:0] v_data [8];
  logic [4:0]  v_sh   [8];
  logic [31:0] v_exp  [8];
  logic [4:0]  v_tag  [8];

`ifdef SHIFT_ROTATE_EN
  localparam logic [31:0] ROR_FF_8 = 32'hFF00_0000;
  localparam logic [31:0] ROR_1_1  = 32'h8000_0000;
`else
  localparam logic [31:0] ROR_FF_8 = 32'h0000_0000;
  localparam logic [31:0] ROR_1_1  = 32'h0000_0000;
`endif

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] d,
                       input logic [4:0] sh, input logic [4:0] tg);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = d;
    bus.in_shamt = sh;
    bus.in_tag   = tg;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic set_vec(input int i, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] sh, input logic [31:0] exp, input logic [4:0] tg);
    v_op[i]   = op;
    v_data[i] = d;
    v_sh[i]   = sh;
    v_exp[i]  = exp;
    v_tag[i]  = tg;
  endtask

  // Streams vectors first_in..n-1, checks all n results in order.
  task automatic run_vectors(input int n, input int first_in, input string name);
    int   ii;
    int   oi;
    int   cyc;
    logic acc;
    ii  = first_in;
    oi  = 0;
    cyc = 0;
    while (oi < n && cyc < 60) begin
      if (ii < n) drive(v_op[ii], v_data[ii], v_sh[ii], v_tag[ii]);
      else        idle();
      #1;
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        check_val($sformatf("%s_data%0d", name, oi), bus.out_data, v_exp[oi]);
        check_val($sformatf("%s_tag%0d", name, oi), 32'(bus.out_tag), 32'(v_tag[oi]));
        oi++;
      end
      tick();
      if (acc) ii++;
      cyc++;
    end
    idle();
    check_val({name, "_count"}, 32'(oi), 32'(n));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_op     = SHIFT_SLL;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_out_data", bus.out_data, 32'd0);
    check_val("rst_out_tag", 32'(bus.out_tag), 32'd0);
    reset = 1'b0;
    #1;
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();

    // SLL 1 by 31, latency 5
    drive(SHIFT_SLL, 32'h0000_0001, 5'd31, 5'd7);
    #1;
    check_val("sll_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    idle();
    repeat (3) tick();
    check_val("sll_lat4_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check_val("sll_valid", 32'(bus.out_valid), 32'd1);
    check_val("sll_data", bus.out_data, 32'h8000_0000);
    check_val("sll_tag", 32'(bus.out_tag), 32'd7);
    tick();
    check_val("sll_drained", 32'(bus.out_valid), 32'd0);

    // SRA then SRL back-to-back
    drive(SHIFT_SRA, 32'h8000_0000, 5'd4, 5'd1);
    tick();
    drive(SHIFT_SRL, 32'h8000_0000, 5'd4, 5'd2);
    tick();
    idle();
    repeat (3) tick();
    check_val("sra_valid", 32'(bus.out_valid), 32'd1);
    check_val("sra_data", bus.out_data, 32'hF800_0000);
    check_val("sra_tag", 32'(bus.out_tag), 32'd1);
    tick();
    check_val("srl_valid", 32'(bus.out_valid), 32'd1);
    check_val("srl_data", bus.out_data, 32'h0800_0000);
    check_val("srl_tag", 32'(bus.out_tag), 32'd2);
    tick();
    check_val("b2b_drained", 32'(bus.out_valid), 32'd0);

    // ROR 0xFF by 8
    drive(SHIFT_ROR, 32'h0000_00FF, 5'd8, 5'd3);
    tick();
    idle();
    repeat (4) tick();
    check_val("ror_valid", 32'(bus.out_valid), 32'd1);
    check_val("ror_data", bus.out_data, ROR_FF_8);
    tick();

    // Boundary amounts, streamed at full rate
    set_vec(0, SHIFT_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 5'd1);
    set_vec(1, SHIFT_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 5'd2);
    set_vec(2, SHIFT_SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 5'd3);
    set_vec(3, SHIFT_SLL, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 5'd4);
    set_vec(4, SHIFT_ROR, 32'h1357_9BDF, 5'd0,  32'h1357_9BDF, 5'd5);
    set_vec(5, SHIFT_SRA, 32'hC000_0001, 5'd0,  32'hC000_0001, 5'd6);
    set_vec(6, SHIFT_SRA, 32'h8000_0000, 5'd17, 32'hFFFF_C000, 5'd7);
    set_vec(7, SHIFT_ROR, 32'h0000_0001, 5'd1,  ROR_1_1,       5'd8);
    run_vectors(8, 0, "edge");
    tick();

    // Backpressure: 7 ops, shamt 0..6, consumer stalled
    set_vec(0, SHIFT_SLL, 32'h1234_5678, 5'd0, 32'h1234_5678, 5'd10);
    set_vec(1, SHIFT_SRA, 32'h8000_0000, 5'd1, 32'hC000_0000, 5'd11);
    set_vec(2, SHIFT_SRL, 32'hF000_0000, 5'd2, 32'h3C00_0000, 5'd12);
    set_vec(3, SHIFT_SLL, 32'h0000_0001, 5'd3, 32'h0000_0008, 5'd13);
    set_vec(4, SHIFT_SRA, 32'h7FFF_FFFF, 5'd4, 32'h07FF_FFFF, 5'd14);
    set_vec(5, SHIFT_SRL, 32'h8000_0001, 5'd5, 32'h0400_0000, 5'd15);
    set_vec(6, SHIFT_SLL, 32'h0000_000F, 5'd6, 32'h0000_03C0, 5'd16);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(v_op[i], v_data[i], v_sh[i], v_tag[i]);
      #1;
      check_val($sformatf("bp_ready%0d", i), 32'(bus.in_ready), 32'd1);
      tick();
    end
    drive(v_op[5], v_data[5], v_sh[5], v_tag[5]);
    #1;
    check_val("bp_full_ready", 32'(bus.in_ready), 32'd0);
    check_val("bp_full_valid", 32'(bus.out_valid), 32'd1);
    check_val("bp_head_data", bus.out_data, 32'h1234_5678);
    repeat (2) tick();
    check_val("bp_hold_data", bus.out_data, 32'h1234_5678);
    check_val("bp_hold_tag", 32'(bus.out_tag), 32'd10);
    check_val("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    run_vectors(7, 5, "bp");
    tick();

    // Flush with three ops in flight
    for (int i = 1; i <= 3; i++) begin
      drive(SHIFT_SLL, 32'h0000_0001, 5'(i), 5'(i));
      tick();
    end
    flush = 1'b1;
    drive(SHIFT_SLL, 32'h0000_DEAD, 5'd0, 5'd20);
    #1;
    check_val("flush_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    flush = 1'b0;
    check_val("flush_clear", 32'(bus.out_valid), 32'd0);
    drive(SHIFT_SLL, 32'h0000_00A5, 5'd4, 5'd9);
    tick();
    idle();
    seen = 0;
    repeat (3) begin
      if (bus.out_valid) seen++;
      tick();
    end
    if (bus.out_valid) seen++;
    check_val("flush_quiet", 32'(seen), 32'd0);
    tick();
    check_val("flush_new_valid", 32'(bus.out_valid), 32'd1);
    check_val("flush_new_data", bus.out_data, 32'h0000_0A50);
    check_val("flush_new_tag", 32'(bus.out_tag), 32'd9);
    tick();

    // Reset in the middle of a stream
    for (int i = 0; i < 6; i++) begin
      drive(SHIFT_SRL, 32'hF000_0000, 5'(i), 5'(i));
      tick();
    end
    check_val("mid_pre_valid", 32'(bus.out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_val("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("mid_rst_data", bus.out_data, 32'd0);
    check_val("mid_rst_tag", 32'(bus.out_tag), 32'd0);
    idle();
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check_val("mid_post_ready", 32'(bus.in_ready), 32'd1);
    check_val("mid_post_valid", 32'(bus.out_valid), 32'd0);
    drive(SHIFT_SRA, 32'h8000_0000, 5'd1, 5'd21);
    tick();
    idle();
    repeat (4) tick();
    check_val("mid_new_valid", 32'(bus.out_valid), 32'd1);
    check_val("mid_new_data", bus.out_data, 32'hC000_0000);
    check_val("mid_new_tag", 32'(bus.out_tag), 32'd21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
